// File: rtl/fifo_ctrl.sv
// First-word-fall-through FIFO controller for an external sync-write/async-read register file.
// Generates storage write enable and addresses, occupancy, threshold flags and sticky error flags.
module fifo_ctrl #(
   parameter int ADDR_WIDTH = 2,
   parameter int AF_LEVEL   = 3,
   parameter int AE_LEVEL   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr,
   input  logic                  rd,
   input  logic                  clr_err,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [ADDR_WIDTH-1:0] r_addr,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
   localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);

   logic [ADDR_WIDTH-1:0] w_ptr_reg, w_ptr_next;
   logic [ADDR_WIDTH-1:0] r_ptr_reg, r_ptr_next;
   logic [ADDR_WIDTH:0]   count_reg, count_next;
   logic                  overflow_reg, overflow_next;
   logic                  underflow_reg, underflow_next;
   logic                  push_ok, pop_ok;

   // A full FIFO still accepts a push when a pop frees the head slot in the same edge.
   assign push_ok = wr & (~full | rd);
   assign pop_ok  = rd & ~empty;

   always_comb begin
      w_ptr_next     = w_ptr_reg;
      r_ptr_next     = r_ptr_reg;
      count_next     = count_reg;
      if (push_ok) begin
         w_ptr_next = w_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
         r_ptr_next = r_ptr_reg + 1'b1;
      end
      if (push_ok && !pop_ok) begin
         count_next = count_reg + 1'b1;
      end else if (!push_ok && pop_ok) begin
         count_next = count_reg - 1'b1;
      end
      // A fresh error outranks a clear arriving in the same cycle.
      overflow_next  = (overflow_reg & ~clr_err) | (wr & ~push_ok);
      underflow_next = (underflow_reg & ~clr_err) | (rd & ~pop_ok);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         w_ptr_reg     <= '0;
         r_ptr_reg     <= '0;
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         w_ptr_reg     <= w_ptr_next;
         r_ptr_reg     <= r_ptr_next;
         count_reg     <= count_next;
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
      end
   end

   assign wr_en        = push_ok;
   assign w_addr       = w_ptr_reg;
   assign r_addr       = r_ptr_reg;
   assign count        = count_reg;
   assign full         = (count_reg == DEPTH_C);
   assign empty        = (count_reg == '0);
   assign almost_full  = (count_reg >= AF_C);
   assign almost_empty = (count_reg <= AE_C);
   assign overflow     = overflow_reg;
   assign underflow    = underflow_reg;

endmodule
